branch_fb_queue: RTL and testbench
==================================

BRANCH_FB_QUEUE -- requirements
Module: branch_fb_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of in-flight branch entries; power of two, 2 to 64.
REQ-002 Parameter ADDR_WIDTH, default 32, PC width.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_pred_valid  input  1  fetch issues a predicted branch this cycle.
REQ-006 i_pred_pc  input  ADDR_WIDTH  PC of the predicted branch.
REQ-007 i_pred_outcome  input  BranchOutcome  prediction given at fetch.
REQ-008 o_pred_ready  output  1  queue can accept an entry; 1 when not full.
REQ-009 i_res_valid  input  1  execute resolves the oldest in-flight branch.
REQ-010 i_res_pc  input  ADDR_WIDTH  PC of the resolved branch.
REQ-011 i_res_outcome  input  BranchOutcome  actual outcome.
REQ-012 i_flush  input  1  discard all unresolved entries (wrong path).
REQ-013 o_fb_valid  output  1  feedback strobe to the predictor.
REQ-014 o_fb_pc  output  ADDR_WIDTH  feedback PC.
REQ-015 o_fb_prediction  output  BranchOutcome  stored prediction.
REQ-016 o_fb_outcome  output  BranchOutcome  resolved outcome.
REQ-017 o_err_underflow  output  1  one-cycle pulse: resolution while empty.
REQ-018 o_err_mismatch  output  1  one-cycle pulse: i_res_pc differs from head PC.
REQ-019 o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-020 o_stat_branches, o_stat_mispredicts  output  32 each  statistics counters.

Function
REQ-021 Circular buffer with head, tail and count registers; entry = {pc, prediction}.
REQ-022 Enqueue when i_pred_valid && o_pred_ready && !i_flush: write at tail; tail wraps DEPTH-1 to 0.
REQ-023 o_pred_ready depends on count only; when full, enqueue is refused even if a dequeue occurs in the same cycle.
REQ-024 Dequeue when i_res_valid and count>0: head advances with wrap.
REQ-025 Feedback is registered with 1-cycle latency: o_fb_* valid in the cycle after dequeue, for exactly one cycle.
REQ-026 o_fb_pc and o_fb_prediction come from the head entry; o_fb_outcome = i_res_outcome.
REQ-027 Mismatch: feedback still emitted from the head entry; o_err_mismatch pulses with o_fb_valid.
REQ-028 i_res_valid with count==0: no dequeue; o_fb_valid stays 0; o_err_underflow pulses next cycle.
REQ-029 Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
REQ-030 i_flush: count, head and tail all go to 0 next cycle; any resolution in the same cycle still produces feedback; the same-cycle enqueue is dropped.
REQ-031 o_count is a registered value equal to count.

Reset
REQ-032 While rst_n=0 at a clock edge, head/tail/count=0, o_fb_valid=0, o_err_*=0, stat counters=0, o_pred_ready=1 the following cycle.
REQ-033 Reset mid-operation discards all entries and any pending feedback; entry storage need not be cleared.

Configuration
REQ-034 With BRANCH_FB_STATS_EN defined: o_stat_branches increments on each o_fb_valid, o_stat_mispredicts increments when o_fb_prediction!=o_fb_outcome; both saturate at 32'hFFFF_FFFF.
REQ-035 Without BRANCH_FB_STATS_EN: ports remain and are constant 0; no counter logic is synthesized.

Structure
REQ-036 mips_core_pkg holds typedef branch_fb_entry_t {pc, prediction} and reuses BranchOutcome; DEPTH remains a module parameter.
REQ-037 No sub-module; storage is an internal register array.

Verification
REQ-038 Reset, enqueue pc 0x100/TAKEN, resolve 0x100/NOT_TAKEN -> next cycle o_fb_valid=1, pc 0x100, pred TAKEN, outcome NOT_TAKEN; mispredicts=1.
REQ-039 Enqueue 8 entries (DEPTH=8) -> o_pred_ready=0, o_count=8; 9th enqueue with a same-cycle resolve is refused; count ends at 7.
REQ-040 Wrap: 20 enqueue/resolve pairs, PCs 0x0..0x4C -> feedback in order with correct PCs; o_count never exceeds 1.
REQ-041 3 entries queued, then i_flush with a resolve of the head -> one feedback for the head, o_count=0 next cycle, same-cycle enqueue dropped.
REQ-042 Resolve on empty queue -> o_err_underflow one-cycle pulse, no o_fb_valid; resolve pc 0x200 against head 0x104 -> feedback pc 0x104, o_err_mismatch=1.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome encoding and branch-feedback queue entry.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Widest PC a queue entry can hold; queue instances use ADDR_WIDTH <= this.
    localparam int unsigned FB_PC_WIDTH = 32;

    typedef struct packed {
        logic [FB_PC_WIDTH-1:0] pc;
        BranchOutcome           prediction;
    } branch_fb_entry_t;

endpackage

// File: rtl/branch_fb_queue.sv
// Branch feedback queue: holds predicted branches in flight between fetch and
// execute, and returns {pc, prediction, outcome} to the predictor on resolution.
// Optional statistics counters are built when BRANCH_FB_STATS_EN is defined;
// otherwise the statistics ports are tied to zero.
module branch_fb_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = FB_PC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_pred_valid,
    input  logic [ADDR_WIDTH-1:0]      i_pred_pc,
    input  BranchOutcome               i_pred_outcome,
    output logic                       o_pred_ready,
    input  logic                       i_res_valid,
    input  logic [ADDR_WIDTH-1:0]      i_res_pc,
    input  BranchOutcome               i_res_outcome,
    input  logic                       i_flush,
    output logic                       o_fb_valid,
    output logic [ADDR_WIDTH-1:0]      o_fb_pc,
    output BranchOutcome               o_fb_prediction,
    output BranchOutcome               o_fb_outcome,
    output logic                       o_err_underflow,
    output logic                       o_err_mismatch,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [31:0]                o_stat_branches,
    output logic [31:0]                o_stat_mispredicts
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAT_W = 32;

    branch_fb_entry_t       mem_q [DEPTH];

    logic [PTR_W-1:0]       head_q, head_n;
    logic [PTR_W-1:0]       tail_q, tail_n;
    logic [CNT_W-1:0]       count_q, count_n;
    logic                   ready_q, ready_n;

    logic                   enq;
    logic                   deq;
    logic                   underflow;
    logic [ADDR_WIDTH-1:0]  head_pc;
    BranchOutcome           head_pred;

    logic                   fb_valid_q;
    logic [ADDR_WIDTH-1:0]  fb_pc_q;
    BranchOutcome           fb_pred_q;
    BranchOutcome           fb_out_q;
    logic                   err_underflow_q;
    logic                   err_mismatch_q;

    // Handshake decode and next pointer/occupancy state; flush wins over everything.
    always_comb begin
        enq       = 1'b0;
        deq       = 1'b0;
        underflow = 1'b0;
        head_n    = head_q;
        tail_n    = tail_q;
        count_n   = count_q;
        ready_n   = ready_q;
        head_pc   = ADDR_WIDTH'(mem_q[head_q].pc);
        head_pred = mem_q[head_q].prediction;

        enq       = i_pred_valid && ready_q && !i_flush;
        deq       = i_res_valid && (count_q != '0);
        underflow = i_res_valid && (count_q == '0);

        if (i_flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else begin
            if (enq) tail_n = tail_q + PTR_W'(1);
            if (deq) head_n = head_q + PTR_W'(1);
            count_n = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
        ready_n = (count_n != CNT_W'(DEPTH));
    end

    // Pointer, occupancy and ready registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            ready_q <= ready_n;
        end
    end

    // Entry storage; contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= '{pc: FB_PC_WIDTH'(i_pred_pc), prediction: i_pred_outcome};
        end
    end

    // Registered feedback and error pulses, one cycle after the resolution.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_valid_q      <= 1'b0;
            fb_pc_q         <= '0;
            fb_pred_q       <= NOT_TAKEN;
            fb_out_q        <= NOT_TAKEN;
            err_underflow_q <= 1'b0;
            err_mismatch_q  <= 1'b0;
        end else begin
            fb_valid_q      <= deq;
            err_underflow_q <= underflow;
            err_mismatch_q  <= deq && (i_res_pc != head_pc);
            if (deq) begin
                fb_pc_q   <= head_pc;
                fb_pred_q <= head_pred;
                fb_out_q  <= i_res_outcome;
            end
        end
    end

    assign o_pred_ready    = ready_q;
    assign o_count         = count_q;
    assign o_fb_valid      = fb_valid_q;
    assign o_fb_pc         = fb_pc_q;
    assign o_fb_prediction = fb_pred_q;
    assign o_fb_outcome    = fb_out_q;
    assign o_err_underflow = err_underflow_q;
    assign o_err_mismatch  = err_mismatch_q;

`ifdef BRANCH_FB_STATS_EN
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_mis_q;

    // Saturating counters over the feedback stream seen by the predictor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (fb_valid_q) begin
            if (stat_br_q != '1) stat_br_q <= stat_br_q + STAT_W'(1);
            if ((fb_pred_q != fb_out_q) && (stat_mis_q != '1)) begin
                stat_mis_q <= stat_mis_q + STAT_W'(1);
            end
        end
    end

    assign o_stat_branches    = stat_br_q;
    assign o_stat_mispredicts = stat_mis_q;
`else
    assign o_stat_branches    = STAT_W'(0);
    assign o_stat_mispredicts = STAT_W'(0);
`endif

endmodule

// File: tb/tb_branch_fb_queue.sv
// Directed bench for branch_fb_queue (DEPTH=8, ADDR_WIDTH=32).
module tb_branch_fb_queue;
    import mips_core_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;

    logic               clk;
    logic               rst_n;
    logic               i_pred_valid;
    logic [AW-1:0]      i_pred_pc;
    BranchOutcome       i_pred_outcome;
    logic               o_pred_ready;
    logic               i_res_valid;
    logic [AW-1:0]      i_res_pc;
    BranchOutcome       i_res_outcome;
    logic               i_flush;
    logic               o_fb_valid;
    logic [AW-1:0]      o_fb_pc;
    BranchOutcome       o_fb_prediction;
    BranchOutcome       o_fb_outcome;
    logic               o_err_underflow;
    logic               o_err_mismatch;
    logic [3:0]         o_count;
    logic [31:0]        o_stat_branches;
    logic [31:0]        o_stat_mispredicts;

    int total = 0;
    int bad   = 0;

    branch_fb_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_pred_valid       (i_pred_valid),
        .i_pred_pc          (i_pred_pc),
        .i_pred_outcome     (i_pred_outcome),
        .o_pred_ready       (o_pred_ready),
        .i_res_valid        (i_res_valid),
        .i_res_pc           (i_res_pc),
        .i_res_outcome      (i_res_outcome),
        .i_flush            (i_flush),
        .o_fb_valid         (o_fb_valid),
        .o_fb_pc            (o_fb_pc),
        .o_fb_prediction    (o_fb_prediction),
        .o_fb_outcome       (o_fb_outcome),
        .o_err_underflow    (o_err_underflow),
        .o_err_mismatch     (o_err_mismatch),
        .o_count            (o_count),
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_pred_valid = 1'b0;
        i_res_valid  = 1'b0;
        i_flush      = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_br;
        logic [31:0] exp_mis;
        rst_n          = 1'b0;
        i_pred_valid   = 1'b0;
        i_pred_pc      = '0;
        i_pred_outcome = NOT_TAKEN;
        i_res_valid    = 1'b0;
        i_res_pc       = '0;
        i_res_outcome  = NOT_TAKEN;
        i_flush        = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_ready", 32'(o_pred_ready), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_fb_valid", 32'(o_fb_valid), 32'd0);
        chk("rst_underflow", 32'(o_err_underflow), 32'd0);
        chk("rst_mismatch", 32'(o_err_mismatch), 32'd0);
        chk("rst_stat_br", o_stat_branches, 32'd0);
        chk("rst_stat_mis", o_stat_mispredicts, 32'd0);

        // Single mispredicted branch
        i_pred_valid = 1'b1; i_pred_pc = 32'h100; i_pred_outcome = TAKEN;
        step(); idle();
        chk("t1_count", 32'(o_count), 32'd1);
        chk("t1_fb_idle", 32'(o_fb_valid), 32'd0);
        i_res_valid = 1'b1; i_res_pc = 32'h100; i_res_outcome = NOT_TAKEN;
        step(); idle();
        chk("t1_fb_valid", 32'(o_fb_valid), 32'd1);
        chk("t1_fb_pc", o_fb_pc, 32'h100);
        chk("t1_fb_pred", 32'(o_fb_prediction), 32'(TAKEN));
        chk("t1_fb_out", 32'(o_fb_outcome), 32'(NOT_TAKEN));
        chk("t1_mismatch", 32'(o_err_mismatch), 32'd0);
        chk("t1_count0", 32'(o_count), 32'd0);
        step();
        chk("t1_fb_pulse", 32'(o_fb_valid), 32'd0);
`ifdef BRANCH_FB_STATS_EN
        exp_br = 32'd1; exp_mis = 32'd1;
`else
        exp_br = 32'd0; exp_mis = 32'd0;
`endif
        chk("t1_stat_br", o_stat_branches, exp_br);
        chk("t1_stat_mis", o_stat_mispredicts, exp_mis);

        // Fill to DEPTH; odd entries predicted taken
        for (int i = 0; i < 8; i++) begin
            i_pred_valid   = 1'b1;
            i_pred_pc      = 32'h300 + 32'(4 * i);
            i_pred_outcome = (i % 2 == 1) ? TAKEN : NOT_TAKEN;
            step();
        end
        idle();
        chk("t2_full_count", 32'(o_count), 32'd8);
        chk("t2_full_ready", 32'(o_pred_ready), 32'd0);
        // Enqueue while full with same-cycle resolve: enqueue must be refused
        i_pred_valid = 1'b1; i_pred_pc = 32'h400; i_pred_outcome = TAKEN;
        i_res_valid = 1'b1; i_res_pc = 32'h300; i_res_outcome = TAKEN;
        step(); idle();
        chk("t2_refuse_count", 32'(o_count), 32'd7);
        chk("t2_refuse_ready", 32'(o_pred_ready), 32'd1);
        chk("t2_fb0_pc", o_fb_pc, 32'h300);
        chk("t2_fb0_pred", 32'(o_fb_prediction), 32'(NOT_TAKEN));
        for (int i = 1; i < 8; i++) begin
            i_res_valid = 1'b1; i_res_pc = 32'h300 + 32'(4 * i); i_res_outcome = TAKEN;
            step(); idle();
            chk("t2_drain_valid", 32'(o_fb_valid), 32'd1);
            chk("t2_drain_pc", o_fb_pc, 32'h300 + 32'(4 * i));
            chk("t2_drain_pred", 32'(o_fb_prediction), (i % 2 == 1) ? 32'(TAKEN) : 32'(NOT_TAKEN));
            chk("t2_drain_count", 32'(o_count), 32'(7 - i));
        end
        // The refused 0x400 must not be present
        i_res_valid = 1'b1; i_res_pc = 32'h400;
        step(); idle();
        chk("t2_empty_fb", 32'(o_fb_valid), 32'd0);
        chk("t2_empty_uf", 32'(o_err_underflow), 32'd1);

        // Wrap: overlapped enqueue k / resolve k-1
        for (int k = 0; k <= 20; k++) begin
            i_pred_valid   = (k < 20);
            i_pred_pc      = 32'(4 * k);
            i_pred_outcome = (k % 2 == 1) ? TAKEN : NOT_TAKEN;
            i_res_valid    = (k > 0);
            i_res_pc       = 32'(4 * (k - 1));
            i_res_outcome  = (k % 2 == 0) ? TAKEN : NOT_TAKEN;
            step();
            chk("t3_count", 32'(o_count), (k < 20) ? 32'd1 : 32'd0);
            chk("t3_fb_valid", 32'(o_fb_valid), (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) chk("t3_fb_pc", o_fb_pc, 32'(4 * (k - 1)));
        end
        idle();

        // Flush with same-cycle head resolve and enqueue
        for (int i = 0; i < 3; i++) begin
            i_pred_valid = 1'b1; i_pred_pc = 32'h500 + 32'(4 * i); i_pred_outcome = TAKEN;
            step();
        end
        idle();
        chk("t4_count3", 32'(o_count), 32'd3);
        i_flush = 1'b1;
        i_res_valid = 1'b1; i_res_pc = 32'h500; i_res_outcome = TAKEN;
        i_pred_valid = 1'b1; i_pred_pc = 32'h600;
        step(); idle();
        chk("t4_fb_valid", 32'(o_fb_valid), 32'd1);
        chk("t4_fb_pc", o_fb_pc, 32'h500);
        chk("t4_count0", 32'(o_count), 32'd0);
        step();
        chk("t4_single_fb", 32'(o_fb_valid), 32'd0);
        // Empty resolve confirms the dropped enqueue
        i_res_valid = 1'b1; i_res_pc = 32'h600;
        step(); idle();
        chk("t5_uf_pulse", 32'(o_err_underflow), 32'd1);
        chk("t5_uf_no_fb", 32'(o_fb_valid), 32'd0);
        step();
        chk("t5_uf_clear", 32'(o_err_underflow), 32'd0);

        // PC mismatch
        i_pred_valid = 1'b1; i_pred_pc = 32'h104; i_pred_outcome = TAKEN;
        step(); idle();
        i_res_valid = 1'b1; i_res_pc = 32'h200; i_res_outcome = TAKEN;
        step(); idle();
        chk("t6_fb_valid", 32'(o_fb_valid), 32'd1);
        chk("t6_fb_pc", o_fb_pc, 32'h104);
        chk("t6_mismatch", 32'(o_err_mismatch), 32'd1);
        chk("t6_count", 32'(o_count), 32'd0);
        step();
        chk("t6_mm_clear", 32'(o_err_mismatch), 32'd0);
`ifdef BRANCH_FB_STATS_EN
        exp_br = 32'd31; exp_mis = 32'd5;
`else
        exp_br = 32'd0; exp_mis = 32'd0;
`endif
        chk("t6_stat_br", o_stat_branches, exp_br);
        chk("t6_stat_mis", o_stat_mispredicts, exp_mis);

        // Reset mid-operation with a pending resolve
        for (int i = 0; i < 2; i++) begin
            i_pred_valid = 1'b1; i_pred_pc = 32'h700 + 32'(4 * i); i_pred_outcome = TAKEN;
            step();
        end
        idle();
        chk("t7_count2", 32'(o_count), 32'd2);
        rst_n = 1'b0;
        i_res_valid = 1'b1; i_res_pc = 32'h700;
        step();
        rst_n = 1'b1; idle();
        chk("t7_count", 32'(o_count), 32'd0);
        chk("t7_fb_valid", 32'(o_fb_valid), 32'd0);
        chk("t7_ready", 32'(o_pred_ready), 32'd1);
        chk("t7_stat_br", o_stat_branches, 32'd0);
        step();
        chk("t7_fb_after", 32'(o_fb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
